// File: rtl/mi32_reg_pkg.sv
// rtl/mi32_reg_pkg.sv - shared MI32 constants, pipeline entry type and byte-merge helper
package mi32_reg_pkg;

  localparam int MI32_DW  = 32;
  localparam int MI32_BEW = 4;

  localparam logic [MI32_DW-1:0] MI32_ID_VALUE = 32'h4D49_3332;

  localparam int REG_ID   = 0;
  localparam int REG_WCNT = 1;

  typedef struct packed {
    logic               valid;
    logic [MI32_DW-1:0] data;
  } rd_entry_t;

  function automatic logic [MI32_DW-1:0] be_merge(
    input logic [MI32_DW-1:0]  old_word,
    input logic [MI32_DW-1:0]  new_word,
    input logic [MI32_BEW-1:0] be
  );
    logic [MI32_DW-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MI32_BEW; b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mi32_rd_pipe.sv
// rtl/mi32_rd_pipe.sv - fixed-depth in-order read return pipeline driving DRDY/DRD
module mi32_rd_pipe
  import mi32_reg_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  rd_entry_t          in_entry,
  output logic               drdy,
  output logic [MI32_DW-1:0] drd
);

  rd_entry_t stage_q [DEPTH];
  rd_entry_t stage_d [DEPTH];

  // Data only advances alongside a valid token, so the last stage holds
  // the most recent returned word while DRDY is low.
  always_comb begin
    stage_d[0].valid = in_entry.valid;
    stage_d[0].data  = in_entry.valid ? in_entry.data : stage_q[0].data;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i].valid = stage_q[i-1].valid;
      stage_d[i].data  = stage_q[i-1].valid ? stage_q[i-1].data : stage_q[i].data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign drdy = stage_q[DEPTH-1].valid;
  assign drd  = stage_q[DEPTH-1].data;

endmodule

// File: rtl/mi32_reg_slave.sv
// rtl/mi32_reg_slave.sv - MI32 slave with ID, write counter and byte-enabled register bank
module mi32_reg_slave
  import mi32_reg_pkg::*;
#(
  parameter int                 REGS         = 16,
  parameter int                 READ_LATENCY = 2,
  parameter logic [MI32_DW-1:0] ID_VALUE     = MI32_ID_VALUE
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [MI32_DW-1:0]  DWR,
  input  logic [31:0]         ADDR,
  input  logic [MI32_BEW-1:0] BE,
  input  logic                RD,
  input  logic                WR,
  output logic                ARDY,
  output logic [MI32_DW-1:0]  DRD,
  output logic                DRDY
);

  localparam int AW = $clog2(REGS);

  logic               ardy_q;
  logic               ardy_d;
  logic [MI32_DW-1:0] wcnt_q;
  logic [MI32_DW-1:0] wcnt_d;
  logic [MI32_DW-1:0] regs_q [REGS];
  logic [MI32_DW-1:0] regs_d [REGS];

  logic [AW-1:0]      widx;
  logic               in_range;
  logic               accept_rd;
  logic               accept_wr;
  logic [MI32_DW-1:0] rd_data;
  rd_entry_t          rd_entry;
  logic               unused_addr_lsb;

  assign widx            = ADDR[AW+1:2];
  assign in_range        = (ADDR[31:AW+2] == '0);
  assign unused_addr_lsb = ^ADDR[1:0];

  assign accept_rd = RD & ardy_q;
  assign accept_wr = WR & ardy_q;

  assign ardy_d = 1'b1;

  // Read mux looks at current state only, so a same-cycle write is not visible.
  always_comb begin
    rd_data = '0;
    if (in_range) begin
      if (widx == AW'(REG_ID)) begin
        rd_data = ID_VALUE;
      end else if (widx == AW'(REG_WCNT)) begin
        rd_data = wcnt_q;
      end else begin
        rd_data = regs_q[widx];
      end
    end
  end

  always_comb begin
    regs_d = regs_q;
    wcnt_d = wcnt_q;
    if (accept_wr && in_range) begin
      if (widx == AW'(REG_WCNT)) begin
        wcnt_d = '0;
      end else if (widx != AW'(REG_ID)) begin
        wcnt_d       = wcnt_q + 1'b1;
        regs_d[widx] = be_merge(regs_q[widx], DWR, BE);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ardy_q <= 1'b0;
      wcnt_q <= '0;
      for (int i = 0; i < REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      ardy_q <= ardy_d;
      wcnt_q <= wcnt_d;
      for (int i = 0; i < REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign ARDY = ardy_q;

  assign rd_entry.valid = accept_rd;
  assign rd_entry.data  = rd_data;

  mi32_rd_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_rd_pipe (
    .clk      (CLK),
    .rst_n    (RESET),
    .in_entry (rd_entry),
    .drdy     (DRDY),
    .drd      (DRD)
  );

endmodule

// File: tb/tb_mi32_reg_slave.sv
// tb/tb_mi32_reg_slave.sv - table-driven bench for mi32_reg_slave (REGS=16, READ_LATENCY=2)
module tb_mi32_reg_slave;

  logic        CLK;
  logic        RESET;
  logic [31:0] DWR;
  logic [31:0] ADDR;
  logic [3:0]  BE;
  logic        RD;
  logic        WR;
  logic        ARDY;
  logic [31:0] DRD;
  logic        DRDY;

  int compared;
  int mismatched;

  localparam logic [31:0] ID = 32'h4D49_3332;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] dwr;
    logic [3:0]  be;
    logic        exp_ardy;
    logic        exp_drdy;
    logic [31:0] exp_drd;
  } vec_t;

  vec_t vq[$];

  mi32_reg_slave #(
    .REGS        (16),
    .READ_LATENCY(2),
    .ID_VALUE    (32'h4D49_3332)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .DWR  (DWR),
    .ADDR (ADDR),
    .BE   (BE),
    .RD   (RD),
    .WR   (WR),
    .ARDY (ARDY),
    .DRD  (DRD),
    .DRDY (DRDY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] dwr, input logic [3:0] be);
    RD   = rd;
    WR   = wr;
    ADDR = addr;
    DWR  = dwr;
    BE   = be;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] dwr, input logic [3:0] be,
                     input logic exp_ardy, input logic exp_drdy, input logic [31:0] exp_drd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.dwr = dwr; v.be = be;
    v.exp_ardy = exp_ardy; v.exp_drdy = exp_drdy; v.exp_drd = exp_drd;
    vq.push_back(v);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    RESET = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    //   rd    wr    addr           dwr            be     ardy  drdy  drd (observed after the edge)
    add(1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0,  1'b1, 1'b0, 32'h0);
    add(1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0,  1'b1, 1'b0, 32'h0);
    add(1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0,  1'b1, 1'b1, ID);
    add(1'b0, 1'b1, 32'h0000_0008, 32'hAABBCCDD,  4'h5,  1'b1, 1'b0, ID);
    add(1'b1, 1'b0, 32'h0000_0008, 32'h0,         4'h0,  1'b1, 1'b0, ID);
    add(1'b1, 1'b0, 32'h0000_0004, 32'h0,         4'h0,  1'b1, 1'b1, 32'h00BB00DD);
    add(1'b1, 1'b1, 32'h0000_000C, 32'h12345678,  4'hF,  1'b1, 1'b1, 32'h1);
    add(1'b1, 1'b0, 32'h0000_000C, 32'h0,         4'h0,  1'b1, 1'b1, 32'h0);
    add(1'b1, 1'b0, 32'h0000_0004, 32'h0,         4'h0,  1'b1, 1'b1, 32'h12345678);
    add(1'b1, 1'b0, 32'h0000_0008, 32'h0,         4'h0,  1'b1, 1'b1, 32'h2);
    add(1'b1, 1'b0, 32'h0000_000C, 32'h0,         4'h0,  1'b1, 1'b1, 32'h00BB00DD);
    add(1'b1, 1'b0, 32'h0000_0040, 32'h0,         4'h0,  1'b1, 1'b1, 32'h12345678);
    add(1'b1, 1'b0, 32'h1000_0000, 32'h0,         4'h0,  1'b1, 1'b1, 32'h0);
    add(1'b1, 1'b0, 32'h0000_0004, 32'h0,         4'h0,  1'b1, 1'b1, 32'h0);
    add(1'b0, 1'b1, 32'h0000_0040, 32'hFFFFFFFF,  4'hF,  1'b1, 1'b1, 32'h2);
    add(1'b0, 1'b1, 32'h0000_0000, 32'hFFFFFFFF,  4'hF,  1'b1, 1'b0, 32'h2);
    add(1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0,  1'b1, 1'b0, 32'h2);
    add(1'b1, 1'b0, 32'h0000_0004, 32'h0,         4'h0,  1'b1, 1'b1, ID);
    add(1'b0, 1'b1, 32'h0000_0004, 32'h0,         4'h0,  1'b1, 1'b1, 32'h2);
    add(1'b1, 1'b0, 32'h0000_0004, 32'h0,         4'h0,  1'b1, 1'b0, 32'h2);
    add(1'b0, 1'b1, 32'h0000_003F, 32'h11223344,  4'h8,  1'b1, 1'b1, 32'h0);
    add(1'b1, 1'b0, 32'h0000_003D, 32'h0,         4'h0,  1'b1, 1'b0, 32'h0);
    add(1'b1, 1'b0, 32'h0000_0004, 32'h0,         4'h0,  1'b1, 1'b1, 32'h11000000);
    add(1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0,  1'b1, 1'b1, 32'h1);
    add(1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0,  1'b1, 1'b0, 32'h1);

    step();
    step();
    check("rst_ardy", {31'h0, ARDY}, 32'h0);
    check("rst_drdy", {31'h0, DRDY}, 32'h0);
    check("rst_drd",  DRD, 32'h0);

    // Release with the first request already on the bus; the first edge must not take it.
    drive(vq[0].rd, vq[0].wr, vq[0].addr, vq[0].dwr, vq[0].be);
    RESET = 1'b1;
    #1;
    check("first_cycle_ardy", {31'h0, ARDY}, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rd, vq[i].wr, vq[i].addr, vq[i].dwr, vq[i].be);
      step();
      check($sformatf("v%0d_ardy", i), {31'h0, ARDY}, {31'h0, vq[i].exp_ardy});
      check($sformatf("v%0d_drdy", i), {31'h0, DRDY}, {31'h0, vq[i].exp_drdy});
      check($sformatf("v%0d_drd", i),  DRD, vq[i].exp_drd);
    end

    // WCNT wrap and clear-on-write
    force dut.wcnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.wcnt_q;
    drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    step();
    check("wrap_pre_drdy", {31'h0, DRDY}, 32'h0);
    drive(1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF);
    step();
    check("wrap_pre_drd", DRD, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check("wrap_post_drdy", {31'h0, DRDY}, 32'h1);
    check("wrap_post_drd", DRD, 32'h0);

    force dut.wcnt_q = 32'h0000_0005;
    #1;
    release dut.wcnt_q;
    drive(1'b0, 1'b1, 32'h4, 32'hDEADBEEF, 4'h0);
    step();
    drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check("wcnt_clear_drdy", {31'h0, DRDY}, 32'h1);
    check("wcnt_clear_drd", DRD, 32'h0);

    // Reset while reads are in flight
    drive(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    step();
    check("fl_r1_drdy", {31'h0, DRDY}, 32'h0);
    step();
    check("fl_r2_drdy", {31'h0, DRDY}, 32'h1);
    check("fl_r2_drd", DRD, 32'hCAFEF00D);
    step();
    check("fl_r3_drdy", {31'h0, DRDY}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    RESET = 1'b0;
    #1;
    check("fl_async_drdy", {31'h0, DRDY}, 32'h0);
    check("fl_async_drd", DRD, 32'h0);
    check("fl_async_ardy", {31'h0, ARDY}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fl_in_rst%0d_drdy", i), {31'h0, DRDY}, 32'h0);
    end
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("fl_after%0d_drdy", i), {31'h0, DRDY}, 32'h0);
    end
    drive(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check("fl_reread_drdy", {31'h0, DRDY}, 32'h1);
    check("fl_reread_drd", DRD, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
